// File: rtl/multicycle_control_if.sv
// Control/data bundle between the multicycle controller and the regfile/ALU/BRAM datapath.
// The controller uses the master view and the datapath uses the slave view.
interface multicycle_control_if #(
  parameter int WIDTH    = 16,
  parameter int REGBITS  = 4,
  parameter int ADDRBITS = 10
);

  logic [WIDTH-1:0]    mem_rdata;
  logic [WIDTH-1:0]    rd1;
  logic [WIDTH-1:0]    rd2;
  logic [ADDRBITS-1:0] mem_addr;
  logic                mem_we;
  logic [REGBITS-1:0]  ra1;
  logic [REGBITS-1:0]  ra2;
  logic [REGBITS-1:0]  wa;
  logic                regwrite;
  logic [3:0]          opcode;
  logic [3:0]          opext;
  logic [7:0]          imm;
  logic                imm_sel;
  logic                wd_sel;
  logic [ADDRBITS-1:0] pc;
  logic [2:0]          state;

  modport master (
    input  mem_rdata, rd1, rd2,
    output mem_addr, mem_we, ra1, ra2, wa, regwrite,
    output opcode, opext, imm, imm_sel, wd_sel, pc, state
  );

  modport slave (
    output mem_rdata, rd1, rd2,
    input  mem_addr, mem_we, ra1, ra2, wa, regwrite,
    input  opcode, opext, imm, imm_sel, wd_sel, pc, state
  );

endinterface

// File: rtl/multicycle_control.sv
// Multicycle fetch/decode/sequence controller: owns PC and IR and drives every datapath control.
// Strobes and addresses are registered one state ahead so they are glitch-free for the whole state.
module multicycle_control #(
  parameter int WIDTH    = 16,
  parameter int REGBITS  = 4,
  parameter int ADDRBITS = 10
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_ITYPE,
    C_LOAD,
    C_STOR,
    C_JUMP,
    C_BRANCH,
    C_NOP
  } iclass_t;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_BRANCH = 4'b1100;
  localparam logic [3:0] OP_NOP    = 4'b1111;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JUMP  = 4'b1100;

  function automatic iclass_t classify(input logic [WIDTH-1:0] word);
    iclass_t c;
    case (word[15:12])
      OP_RTYPE:  c = C_RTYPE;
      OP_MEM: begin
        case (word[7:4])
          EXT_LOAD: c = C_LOAD;
          EXT_STOR: c = C_STOR;
          EXT_JUMP: c = C_JUMP;
          default:  c = C_NOP;
        endcase
      end
      OP_BRANCH: c = C_BRANCH;
      OP_NOP:    c = C_NOP;
      default:   c = C_ITYPE;
    endcase
    return c;
  endfunction

  // Raw bits rather than state_t so illegal encodings 5-7 stay visible to recovery and debug.
  logic [2:0]          state_q, state_d;
  logic [WIDTH-1:0]    ir_q, ir_d;
  logic [ADDRBITS-1:0] pc_q, pc_d;
  logic [ADDRBITS-1:0] mem_addr_q, mem_addr_d;
  logic                regwrite_q, regwrite_d;
  logic                mem_we_q, mem_we_d;
  logic                imm_sel_q, imm_sel_d;
  logic                wd_sel_q, wd_sel_d;

  iclass_t             cls_ir;
  iclass_t             cls_fetched;
  logic [ADDRBITS-1:0] pc_inc;
  logic [ADDRBITS-1:0] branch_target;
  logic [ADDRBITS-1:0] reg_addr;

  assign cls_ir        = classify(ir_q);
  assign cls_fetched   = classify(bus.mem_rdata);
  assign pc_inc        = pc_q + ADDRBITS'(1);
  // pc already holds the incremented value when EXEC computes the branch target.
  assign branch_target = pc_q + {{(ADDRBITS-8){ir_q[7]}}, ir_q[7:0]};
  assign reg_addr      = bus.rd2[ADDRBITS-1:0];

  // Each next_* value is what the matching output must show in the state being entered.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d    = S_FETCH;
    ir_d       = ir_q;
    pc_d       = pc_q;
    mem_addr_d = pc_q;
    regwrite_d = 1'b0;
    mem_we_d   = 1'b0;
    imm_sel_d  = 1'b0;
    wd_sel_d   = 1'b0;

    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        ir_d    = bus.mem_rdata;
        pc_d    = pc_inc;
        state_d = S_EXEC;
        case (cls_fetched)
          C_RTYPE: regwrite_d = 1'b1;
          C_ITYPE: begin
            regwrite_d = 1'b1;
            imm_sel_d  = 1'b1;
          end
          default: regwrite_d = 1'b0;
        endcase
      end

      S_EXEC: begin
        case (cls_ir)
          C_LOAD: begin
            state_d    = S_MEM;
            mem_addr_d = reg_addr;
          end
          C_STOR: begin
            state_d    = S_MEM;
            mem_addr_d = reg_addr;
            mem_we_d   = 1'b1;
          end
          C_JUMP: begin
            pc_d       = reg_addr;
            mem_addr_d = reg_addr;
          end
          C_BRANCH: begin
            pc_d       = branch_target;
            mem_addr_d = branch_target;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (cls_ir == C_LOAD) begin
          state_d    = S_WB;
          mem_addr_d = mem_addr_q;
          regwrite_d = 1'b1;
          wd_sel_d   = 1'b1;
        end
      end

      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      pc_q       <= '0;
      mem_addr_q <= '0;
      regwrite_q <= 1'b0;
      mem_we_q   <= 1'b0;
      imm_sel_q  <= 1'b0;
      wd_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      regwrite_q <= regwrite_d;
      mem_we_q   <= mem_we_d;
      imm_sel_q  <= imm_sel_d;
      wd_sel_q   <= wd_sel_d;
    end
  end

  // NOTE: the write strobes are gated by reset so a strobe already registered for this cycle never writes.
  assign bus.mem_we   = mem_we_q & ~reset;
  assign bus.regwrite = regwrite_q & ~reset;

  assign bus.mem_addr = mem_addr_q;
  assign bus.imm_sel  = imm_sel_q;
  assign bus.wd_sel   = wd_sel_q;
  assign bus.pc       = pc_q;
  assign bus.state    = state_q;

  assign bus.opcode   = ir_q[15:12];
  assign bus.opext    = ir_q[7:4];
  assign bus.imm      = ir_q[7:0];
  assign bus.ra1      = ir_q[8 +: REGBITS];
  assign bus.ra2      = ir_q[0 +: REGBITS];
  assign bus.wa       = ir_q[8 +: REGBITS];

  // rd1 is store data wired straight to the BRAM; only the low address bits of rd2 matter here.
  logic unused_bits;
  assign unused_bits = ^{bus.rd1, bus.rd2[WIDTH-1:ADDRBITS]};

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Fetch/decode/sequence controller that drives the 16-bit datapath: regfile read/write addresses, ALU opcode/opext, and BRAM port-A address and write enable.
- Holds the PC (10-bit word address) and the instruction register (IR).
- Steps every instruction through a fixed multicycle FSM.
- Sits directly upstream of the regfile/alucontrol/alu/bram datapath: consumes BRAM read data and register read data, produces all of the datapath's control inputs.

Parameters:
WIDTH, 16, datapath/instruction width
REGBITS, 4, register address width
ADDRBITS, 10, memory word-address width (PC width)

Ports:
clk  input  1  system clock, rising-edge; BRAM is clocked on ~clk, so read data is valid before the next rising edge
reset  input  1  synchronous, active-high
mem_rdata  input  WIDTH  BRAM port-A read data (q_a)
rd1  input  WIDTH  regfile read data 1 (register at ra1)
rd2  input  WIDTH  regfile read data 2 (register at ra2)
mem_addr  output  ADDRBITS  BRAM port-A address
mem_we  output  1  BRAM port-A write enable; write data is rd1, wired at top level
ra1  output  REGBITS  regfile read address 1 = IR[11:8] (Rdest)
ra2  output  REGBITS  regfile read address 2 = IR[3:0] (Rsrc)
wa  output  REGBITS  regfile write address = IR[11:8]
regwrite  output  1  regfile write enable
opcode  output  4  IR[15:12] to alucontrol
opext  output  4  IR[7:4] to alucontrol
imm  output  8  IR[7:0]
imm_sel  output  1  1 = ALU B operand is sign-extended imm; 0 = rd2
wd_sel  output  1  regfile write data select: 0 = ALU result, 1 = mem_rdata
pc  output  ADDRBITS  current PC, for debug/LEDs
state  output  3  current FSM state encoding, for debug

Behaviour:
- Instruction fields: opcode=IR[15:12], Rdest=IR[11:8], opext=IR[7:4], Rsrc=IR[3:0], imm=IR[7:0].
- Instruction classes, decoded from IR:
  - R-type: opcode 0000.
  - MEM: opcode 0100. LOAD when opext=0000; STOR when opext=0100; JUMP when opext=1100; any other opext is a NOP.
  - BRANCH: opcode 1100, unconditional.
  - NOP: opcode 1111.
  - I-type ALU: every other opcode.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5-7 are illegal and go to FETCH on the next clock.
- Reset (synchronous, takes effect at the clock edge where reset=1):
  - state=FETCH, pc=0, IR=0.
  - All outputs derived from state/IR take their FETCH values with IR=0: regwrite=0, mem_we=0, imm_sel=0, wd_sel=0, mem_addr=0.
  - Reset overrides everything, including a pending regwrite or mem_we in the same cycle, so no write occurs.
- FETCH: mem_addr=pc. Next: DECODE.
- DECODE: IR<=mem_rdata; pc<=pc+1, wrapping 1023->0. Next: EXEC.
- EXEC: ra1/ra2 are driven from IR (they are combinational from IR in every state).
  - R-type: regwrite=1, wd_sel=0, imm_sel=0. Next: FETCH.
  - I-type: regwrite=1, wd_sel=0, imm_sel=1. Next: FETCH.
  - LOAD/STOR: next MEM.
  - JUMP: pc<=rd2[9:0]. Next: FETCH.
  - BRANCH: pc<=pc+sext(imm), 10-bit modular arithmetic; pc already holds the incremented value. Next: FETCH.
  - NOP/unknown MEM opext: no writes. Next: FETCH.
- MEM: mem_addr=rd2[9:0].
  - STOR: mem_we=1. Next: FETCH.
  - LOAD: next WB.
- WB: mem_addr=rd2[9:0] is held, regwrite=1, wd_sel=1. Next: FETCH.
- Latencies in clocks: ALU/I-type/JUMP/BRANCH/NOP = 3; STOR = 4; LOAD = 5.
- Strobes: regwrite and mem_we are asserted only in the states listed above and for exactly one cycle per instruction.
- Addresses 0x300-0x3FF are memory-mapped I/O, decoded outside this block. This block does not special-case them.

Test Plan:
- Reset: assert reset for 2 cycles mid-STOR (in MEM state) -> mem_we=0 at that edge; after release state=FETCH, pc=0, mem_addr=0.
- R-type: mem[0]=16'h0152 -> DECODE latches it, EXEC shows opcode=0, opext=5, ra1=1, ra2=2, wa=1, regwrite=1 for 1 cycle, imm_sel=0; next FETCH at pc=1; 3 cycles total.
- I-type plus LOAD: mem[1]=16'h5307 -> EXEC imm_sel=1, imm=8'h07, regwrite=1. Then mem[2]=16'h4405 with rd2=16'h0123 -> MEM and WB show mem_addr=0x123; WB has regwrite=1, wd_sel=1, wa=4; 5 cycles total.
- STOR to I/O: mem[0]=16'h4246, rd2=16'h0300 -> MEM state mem_addr=0x300, mem_we=1 for exactly 1 cycle, regwrite stays 0.
- BRANCH wrap: pc=1023, mem[1023]=16'hC0FE (imm=-2) -> pc increments to 0 in DECODE; EXEC sets pc=0x3FE.
- JUMP: mem[5]=16'h40C3 with rd2=16'hFC10 -> next FETCH mem_addr=0x010 (upper bits truncated). Also force an illegal state value -> state returns to FETCH after 1 clock.
